button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000, consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 60_000_000, length of the stretched output after each press event (longer than one 1 Hz slow-clock period).
REQ-003 SHALL have parameter REPEAT_EN, default 2'b01, per-channel auto-repeat enable (bit0 next, bit1 select).
REQ-004 SHALL have parameter REPEAT_DELAY, default 25_000_000, cycles held in PRESSED before the first repeat.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 12_500_000, cycles between subsequent repeats.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock (50 MHz board clock).
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port btn_n_in, input, 2 bits: raw active-low push buttons, bit0 next, bit1 select.
REQ-009 SHALL have port btn_level, output, 2 bits: debounced level, active-high (1 = pressed).
REQ-010 SHALL have port press_pulse, output, 2 bits: one-clk-cycle pulse per accepted press or repeat.
REQ-011 SHALL have port btn_out_n, output, 2 bits: stretched active-low outputs driving the controller's next_button and select_button inputs.

Function
REQ-012 SHALL pass each btn_n_in bit through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-013 SHALL run one independent FSM per channel with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE SHALL go to PRESS_WAIT when the synchronized sample is low, clearing the stable counter.
REQ-015 PRESS_WAIT SHALL return to IDLE on any high sample (bounce restarts qualification), and SHALL go to PRESSED after DEB_CYCLES consecutive low samples.
REQ-016 PRESSED SHALL go to RELEASE_WAIT on a high sample.
REQ-017 RELEASE_WAIT SHALL return to PRESSED on any low sample, and SHALL go to IDLE after DEB_CYCLES consecutive high samples.
REQ-018 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT and 0 otherwise.
REQ-019 press_pulse SHALL be 1 for exactly the one cycle in which the FSM enters PRESSED from PRESS_WAIT; re-entry from RELEASE_WAIT SHALL NOT pulse.
REQ-020 Latency: input falling before edge k and held low SHALL give press_pulse high in the cycle after edge k+1+DEB_CYCLES.
REQ-021 Auto-repeat (REPEAT_EN bit set): in PRESSED, the first repeat pulse SHALL occur REPEAT_DELAY cycles after the entry pulse, then every REPEAT_PERIOD cycles.
REQ-022 Leaving PRESSED SHALL clear the repeat counter; re-entry from RELEASE_WAIT SHALL restart REPEAT_DELAY.
REQ-023 Each press_pulse SHALL load the hold counter with HOLD_CYCLES. btn_out_n SHALL be 0 while the counter is nonzero, so it is low for exactly HOLD_CYCLES cycles starting the cycle after the pulse.
REQ-024 A pulse arriving while the hold counter is nonzero SHALL reload it (retrigger); btn_out_n SHALL stay continuously low.
REQ-025 Simultaneous activity on both channels SHALL be handled independently, with no priority and no interaction.
REQ-026 Counter widths SHALL be $clog2(max parameter + 1); counters SHALL saturate and never wrap.

Reset
REQ-027 While reset=0: synchronizer flops SHALL be 1 (released), every FSM SHALL be in IDLE, all counters SHALL be 0, btn_level=2'b00, press_pulse=2'b00, btn_out_n=2'b11.
REQ-028 Reset asserted mid-press or mid-hold SHALL abort immediately.
REQ-029 A button still held at reset release SHALL be qualified as a new press, pulsing after 2+DEB_CYCLES cycles.

Structure
REQ-030 A shared package (coffee_pkg) SHALL hold the channel-state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), the channel index constants BTN_NEXT=0 and BTN_SELECT=1, and the default timing constants.
REQ-031 One sub-module, debounce_channel, SHALL contain the synchronizer, FSM, repeat and hold logic for a single channel, instantiated twice.

Verification (bench parameters: DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_DELAY=8, REPEAT_PERIOD=3, REPEAT_EN=2'b01)
REQ-032 Clean press: bit1 low from edge 0 -> press_pulse[1] high only in the cycle after edge 5, btn_level[1]=1, btn_out_n[1] low for 10 cycles.
REQ-033 Bounce: bit0 toggling low 3 cycles, high 1 cycle, repeated -> no pulse; a subsequent 4-cycle low -> exactly one pulse.
REQ-034 Repeat: bit0 held 30 cycles -> pulses at entry, entry+8, entry+11, entry+14, ...; btn_out_n[0] continuously low.
REQ-035 Select held 30 cycles -> exactly one pulse (REPEAT_EN bit1=0); release glitch of 2 high cycles -> no new pulse.
REQ-036 Both buttons pressed on the same edge -> both pulses in the same cycle.
REQ-037 Reset pulsed at hold cycle 3 -> btn_out_n=2'b11 at once; button still held -> new pulse 6 cycles after reset release.

Source files
------------

// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared channel state, channel indices and default timing for the button conditioner
package coffee_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int NUM_BTN    = 2;
  localparam int BTN_NEXT   = 0;
  localparam int BTN_SELECT = 1;

  // Defaults sized for a 50 MHz board clock
  localparam int         DEF_DEB_CYCLES    = 1_000_000;
  localparam int         DEF_HOLD_CYCLES   = 60_000_000;
  localparam logic [1:0] DEF_REPEAT_EN     = 2'b01;
  localparam int         DEF_REPEAT_DELAY  = 25_000_000;
  localparam int         DEF_REPEAT_PERIOD = 12_500_000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchronizer, debounce FSM, auto-repeat and output stretcher
module debounce_channel
  import coffee_pkg::*;
#(
  parameter int   DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int   HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic REPEAT_ON     = 1'b0,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_in,
  output logic btn_level,
  output logic press_pulse,
  output logic btn_out_n
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int REP_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  // The sample that moves the FSM out of IDLE (or into RELEASE_WAIT) is the
  // first of the qualifying run, so the counter only has to cover the rest.
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);
  localparam logic [DEB_W-1:0]  DEB_SAT     = DEB_W'(DEB_CYCLES);
  localparam logic [REP_W-1:0]  DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0]  REP_SAT     = REP_W'(REP_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]  deb_inc;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0]  rep_inc;
  logic              rep_period_q, rep_period_d;
  logic              pulse_q, pulse_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sample_n;

  // Two-flop synchronizer feed; the raw pin is never used past this point
  always_comb begin
    sync1_d = btn_n_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops idle released (high) in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_n = sync2_q;

  // Next-state, debounce, repeat and hold counter logic
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    rep_cnt_d    = '0;
    rep_period_d = 1'b0;
    pulse_d      = 1'b0;
    hold_d       = hold_q;

    deb_inc = (deb_cnt_q == DEB_SAT) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
    rep_inc = (rep_cnt_q == REP_SAT) ? rep_cnt_q : rep_cnt_q + REP_W'(1);

    case (state_q)
      IDLE: begin
        if (!sample_n) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (sample_n) begin
          state_d = IDLE;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      PRESSED: begin
        if (sample_n) begin
          // Leaving PRESSED drops the repeat state via the defaults above
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (REPEAT_ON) begin
          rep_period_d = rep_period_q;
          if (rep_cnt_q == (rep_period_q ? PERIOD_LAST : DELAY_LAST)) begin
            pulse_d      = 1'b1;
            rep_cnt_d    = '0;
            rep_period_d = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!sample_n) begin
          // Release bounce: back to PRESSED silently, repeat delay restarts
          state_d = PRESSED;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every visible pulse (re)loads the stretcher
    if (pulse_q) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  // Channel state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      deb_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      rep_period_q <= 1'b0;
      pulse_q      <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_period_q <= rep_period_d;
      pulse_q      <= pulse_d;
      hold_q       <= hold_d;
    end
  end

  assign btn_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_pulse = pulse_q;
  assign btn_out_n   = (hold_q == '0);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two independent debounced, auto-repeating, stretched push-button channels
module button_conditioner
  import coffee_pkg::*;
#(
  parameter int         DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int         HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [1:0] REPEAT_EN     = DEF_REPEAT_EN,
  parameter int         REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int         REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] btn_out_n
);

  debounce_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_ON     (REPEAT_EN[BTN_NEXT]),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_next (
    .clk         (clk),
    .reset       (reset),
    .btn_n_in    (btn_n_in[BTN_NEXT]),
    .btn_level   (btn_level[BTN_NEXT]),
    .press_pulse (press_pulse[BTN_NEXT]),
    .btn_out_n   (btn_out_n[BTN_NEXT])
  );

  debounce_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_ON     (REPEAT_EN[BTN_SELECT]),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_select (
    .clk         (clk),
    .reset       (reset),
    .btn_n_in    (btn_n_in[BTN_SELECT]),
    .btn_level   (btn_level[BTN_SELECT]),
    .press_pulse (press_pulse[BTN_SELECT]),
    .btn_out_n   (btn_out_n[BTN_SELECT])
  );

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with short timing parameters
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int RDLY = 8;
  localparam int RPER = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_n_in;
  logic [1:0] btn_level;
  logic [1:0] press_pulse;
  logic [1:0] btn_out_n;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q0[$];
  int exp_q1[$];
  int e0, e1;

  button_conditioner #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_EN     (2'b01),
    .REPEAT_DELAY  (RDLY),
    .REPEAT_PERIOD (RPER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n_in    (btn_n_in),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .btn_out_n   (btn_out_n)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the next expected cycle
  always @(negedge clk) begin
    if (press_pulse[0] === 1'b1) begin
      vectors++;
      if (exp_q0.size() == 0) begin
        miscompares++;
        $display("FAIL pulse0_unexpected got pulse at cycle %0d expected none", cyc);
      end else begin
        e0 = exp_q0.pop_front();
        if (cyc !== e0) begin
          miscompares++;
          $display("FAIL pulse0_cycle got %0d expected %0d", cyc, e0);
        end
      end
    end
    if (press_pulse[1] === 1'b1) begin
      vectors++;
      if (exp_q1.size() == 0) begin
        miscompares++;
        $display("FAIL pulse1_unexpected got pulse at cycle %0d expected none", cyc);
      end else begin
        e1 = exp_q1.pop_front();
        if (cyc !== e1) begin
          miscompares++;
          $display("FAIL pulse1_cycle got %0d expected %0d", cyc, e1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_pulses got %0d/%0d pending expected 0/0", name, exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_n_in = 2'b11;
    step(2);
    @(negedge clk);
    vectors++;
    if ({btn_level, press_pulse, btn_out_n} !== 6'b00_00_11) begin
      miscompares++;
      $display("FAIL reset_state got %b expected 000011", {btn_level, press_pulse, btn_out_n});
    end
    // Buttons pressed while reset is held must not move anything
    step(1);
    btn_n_in = 2'b00;
    step(6);
    @(negedge clk);
    vectors++;
    if ({btn_level, press_pulse, btn_out_n} !== 6'b00_00_11) begin
      miscompares++;
      $display("FAIL reset_held_press got %b expected 000011", {btn_level, press_pulse, btn_out_n});
    end
    step(1);
    btn_n_in = 2'b11;
    step(3);
    reset = 1'b1;
    step(10);
    @(negedge clk);
    vectors++;
    if ({btn_level, press_pulse, btn_out_n} !== 6'b00_00_11) begin
      miscompares++;
      $display("FAIL reset_release_idle got %b expected 000011", {btn_level, press_pulse, btn_out_n});
    end
  endtask

  task automatic test_clean_press();
    int c, first, last, lowcnt;
    step(1);
    c = cyc;
    first = -1;
    last = -1;
    lowcnt = 0;
    btn_n_in[1] = 1'b0;
    exp_q1.push_back(c + 1 + 1 + DEB);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cyc == c + 5) begin
        vectors++;
        if (btn_level[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL clean_level_early got %b expected 0", btn_level[1]);
        end
      end
      if (cyc == c + 6) begin
        vectors++;
        if (btn_level[1] !== 1'b1 || press_pulse !== 2'b10) begin
          miscompares++;
          $display("FAIL clean_entry got level=%b pulse=%b expected level=1 pulse=10", btn_level[1], press_pulse);
        end
      end
      if (btn_out_n[1] === 1'b0) begin
        lowcnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    vectors++;
    if (first != c + 7 || last != c + 16 || lowcnt != HOLD) begin
      miscompares++;
      $display("FAIL clean_hold got first=%0d last=%0d n=%0d expected first=%0d last=%0d n=%0d",
               first - c, last - c, lowcnt, 7, 16, HOLD);
    end
    // Two-cycle release glitch must be absorbed without a new pulse
    step(1);
    btn_n_in[1] = 1'b1;
    step(2);
    btn_n_in[1] = 1'b0;
    step(10);
    @(negedge clk);
    vectors++;
    if (btn_level[1] !== 1'b1 || btn_out_n[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL select_glitch got level=%b out_n=%b expected level=1 out_n=1", btn_level[1], btn_out_n[1]);
    end
    step(1);
    btn_n_in[1] = 1'b1;
    step(12);
    @(negedge clk);
    vectors++;
    if (btn_level[1] !== 1'b0 || btn_out_n !== 2'b11) begin
      miscompares++;
      $display("FAIL select_release got level=%b out_n=%b expected level=0 out_n=11", btn_level[1], btn_out_n);
    end
    check_drained("clean_press");
  endtask

  task automatic test_bounce();
    int c;
    step(1);
    for (int i = 0; i < 3; i++) begin
      btn_n_in[0] = 1'b0;
      step(3);
      btn_n_in[0] = 1'b1;
      step(1);
    end
    step(8);
    @(negedge clk);
    vectors++;
    if (btn_level[0] !== 1'b0 || btn_out_n[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_rejected got level=%b out_n=%b expected level=0 out_n=1", btn_level[0], btn_out_n[0]);
    end
    step(1);
    c = cyc;
    btn_n_in[0] = 1'b0;
    exp_q0.push_back(c + 6);
    step(4);
    btn_n_in[0] = 1'b1;
    step(22);
    @(negedge clk);
    vectors++;
    if (btn_level[0] !== 1'b0 || btn_out_n[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_settle got level=%b out_n=%b expected level=0 out_n=1", btn_level[0], btn_out_n[0]);
    end
    check_drained("bounce");
  endtask

  task automatic test_repeat();
    int c, first, last, lowcnt;
    step(1);
    c = cyc;
    first = -1;
    last = -1;
    lowcnt = 0;
    btn_n_in[0] = 1'b0;
    // Entry pulse, then +8, then every 3 while the synchronized sample
    // is still low (last low sample reaches the FSM at edge c+32)
    exp_q0.push_back(c + 6);
    for (int t = c + 6 + RDLY; t <= c + 32; t += RPER) exp_q0.push_back(t);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (cyc == c + 30) btn_n_in[0] = 1'b1;
      if (btn_out_n[0] === 1'b0) begin
        lowcnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    vectors++;
    if (first != c + 7 || last != c + 42 || lowcnt != 36) begin
      miscompares++;
      $display("FAIL repeat_hold got first=%0d last=%0d n=%0d expected first=7 last=42 n=36",
               first - c, last - c, lowcnt);
    end
    step(10);
    @(negedge clk);
    vectors++;
    if (btn_level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL repeat_release got level=%b expected 0", btn_level[0]);
    end
    check_drained("repeat");
  endtask

  task automatic test_both();
    int c;
    step(1);
    c = cyc;
    btn_n_in = 2'b00;
    exp_q0.push_back(c + 6);
    exp_q1.push_back(c + 6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc == c + 6) begin
        vectors++;
        if (press_pulse !== 2'b11 || btn_level !== 2'b11) begin
          miscompares++;
          $display("FAIL both_entry got pulse=%b level=%b expected pulse=11 level=11", press_pulse, btn_level);
        end
      end
      if (cyc == c + 10) btn_n_in = 2'b11;
    end
    step(15);
    check_drained("both");
  endtask

  task automatic test_reset_mid_hold();
    int c, r;
    step(1);
    c = cyc;
    btn_n_in[1] = 1'b0;
    exp_q1.push_back(c + 6);
    for (int i = 0; i < 9; i++) @(negedge clk);
    vectors++;
    if (btn_out_n[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_before_reset got %b expected 0", btn_out_n[1]);
    end
    // Third hold cycle: reset must clear everything without waiting for a clock
    step(1);
    reset = 1'b0;
    #1;
    vectors++;
    if ({btn_level, press_pulse, btn_out_n} !== 6'b00_00_11) begin
      miscompares++;
      $display("FAIL reset_abort got %b expected 000011", {btn_level, press_pulse, btn_out_n});
    end
    step(2);
    r = cyc;
    reset = 1'b1;
    exp_q1.push_back(r + 2 + DEB);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc == r + 5) begin
        vectors++;
        if (btn_level[1] !== 1'b0 || btn_out_n !== 2'b11) begin
          miscompares++;
          $display("FAIL reset_requalify_early got level=%b out_n=%b expected level=0 out_n=11", btn_level[1], btn_out_n);
        end
      end
    end
    step(1);
    btn_n_in[1] = 1'b1;
    step(20);
    check_drained("reset_mid_hold");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_both();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
